// File: rtl/rfblackwidow_cond_resolve.sv
// Condition-register file with pending scoreboard and branch resolution FSM.
// Branches stall until the tested CR's compare result arrives, then report taken/mispredict/PC.
//
// state | meaning
// IDLE  | ready for a branch request
// WAIT  | branch latched, tested CR still pending
// DONE  | result presented, held until res_ready_i
module rfblackwidow_cond_resolve #(
  parameter int NCR   = 8,
  parameter int CRW   = $clog2(NCR),
  parameter int ABITS = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             cmp_issue_i,
  input  logic [CRW-1:0]   cmp_issue_cr_i,
  input  logic             cmp_wr_i,
  input  logic [CRW-1:0]   cmp_wr_cr_i,
  input  logic             cmp_res_i,
  input  logic             br_req_i,
  output logic             br_ready_o,
  input  logic [CRW-1:0]   br_cr_i,
  input  logic             br_sense_i,
  input  logic             br_pred_i,
  input  logic [ABITS-1:0] br_target_i,
  input  logic [ABITS-1:0] br_fallthru_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_taken_o,
  output logic             res_mispred_o,
  output logic [ABITS-1:0] res_pc_o,
  output logic [NCR-1:0]   cr_o,
  output logic [NCR-1:0]   pend_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state;
  logic [NCR-1:0]   cr;
  logic [NCR-1:0]   pend;
  logic [NCR-1:0]   pend_nxt;
  logic [CRW-1:0]   lcr;
  logic             lsense;
  logic             lpred;
  logic [ABITS-1:0] ltarget;
  logic [ABITS-1:0] lfall;
  logic             byp_hit;
  logic             req_rdy;
  logic             req_val;
  logic             req_taken;
  logic             wait_hit;
  logic             wait_taken;

  // Issue is applied after write so a same-cycle issue/write leaves the CR pending.
  always_comb begin
    pend_nxt = pend;
    if (cmp_wr_i)    pend_nxt[cmp_wr_cr_i] = 1'b0;
    if (cmp_issue_i) pend_nxt[cmp_issue_cr_i] = 1'b1;
    if (flush_i)     pend_nxt = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cr   <= '0;
      pend <= '0;
    end else begin
      if (cmp_wr_i) cr[cmp_wr_cr_i] <= cmp_res_i;
      pend <= pend_nxt;
    end
  end

  assign byp_hit    = cmp_wr_i && (cmp_wr_cr_i == br_cr_i);
  assign req_rdy    = byp_hit || !pend[br_cr_i];
  assign req_val    = byp_hit ? cmp_res_i : cr[br_cr_i];
  assign req_taken  = (req_val == br_sense_i);
  assign wait_hit   = cmp_wr_i && (cmp_wr_cr_i == lcr);
  assign wait_taken = (cmp_res_i == lsense);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      br_ready_o    <= 1'b1;
      res_valid_o   <= 1'b0;
      res_taken_o   <= 1'b0;
      res_mispred_o <= 1'b0;
      res_pc_o      <= '0;
      lcr           <= '0;
      lsense        <= 1'b0;
      lpred         <= 1'b0;
      ltarget       <= '0;
      lfall         <= '0;
    end else if (flush_i) begin
      state       <= IDLE;
      br_ready_o  <= 1'b1;
      res_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (br_req_i) begin
            lcr        <= br_cr_i;
            lsense     <= br_sense_i;
            lpred      <= br_pred_i;
            ltarget    <= br_target_i;
            lfall      <= br_fallthru_i;
            br_ready_o <= 1'b0;
            if (req_rdy) begin
              state         <= DONE;
              res_valid_o   <= 1'b1;
              res_taken_o   <= req_taken;
              res_mispred_o <= req_taken ^ br_pred_i;
              res_pc_o      <= req_taken ? br_target_i : br_fallthru_i;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_hit) begin
            state         <= DONE;
            res_valid_o   <= 1'b1;
            res_taken_o   <= wait_taken;
            res_mispred_o <= wait_taken ^ lpred;
            res_pc_o      <= wait_taken ? ltarget : lfall;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state       <= IDLE;
            res_valid_o <= 1'b0;
            br_ready_o  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          br_ready_o  <= 1'b1;
          res_valid_o <= 1'b0;
        end
      endcase
    end
  end

  assign cr_o   = cr;
  assign pend_o = pend;

endmodule

// File: tb/tb_rfblackwidow_cond_resolve.sv
// Directed bench for rfblackwidow_cond_resolve: expected results are queued at request
// time and a negedge monitor checks each accepted result against the queue.
module tb_rfblackwidow_cond_resolve;
  localparam int NCR = 8;
  localparam int CRW = 3;
  localparam int AB  = 32;

  logic clk_i = 0, rst_i = 1, flush_i = 0;
  logic cmp_issue_i = 0, cmp_wr_i = 0, cmp_res_i = 0;
  logic [CRW-1:0] cmp_issue_cr_i = 0, cmp_wr_cr_i = 0, br_cr_i = 0;
  logic br_req_i = 0, br_sense_i = 0, br_pred_i = 0, res_ready_i = 0;
  logic [AB-1:0] br_target_i = 0, br_fallthru_i = 0;
  logic br_ready_o, res_valid_o, res_taken_o, res_mispred_o;
  logic [AB-1:0] res_pc_o;
  logic [NCR-1:0] cr_o, pend_o;

  int errors = 0;
  int checks = 0;
  logic [AB+1:0] expq[$];

  rfblackwidow_cond_resolve #(.NCR(NCR), .ABITS(AB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .cmp_issue_i(cmp_issue_i), .cmp_issue_cr_i(cmp_issue_cr_i),
    .cmp_wr_i(cmp_wr_i), .cmp_wr_cr_i(cmp_wr_cr_i), .cmp_res_i(cmp_res_i),
    .br_req_i(br_req_i), .br_ready_o(br_ready_o), .br_cr_i(br_cr_i),
    .br_sense_i(br_sense_i), .br_pred_i(br_pred_i),
    .br_target_i(br_target_i), .br_fallthru_i(br_fallthru_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_taken_o(res_taken_o), .res_mispred_o(res_mispred_o), .res_pc_o(res_pc_o),
    .cr_o(cr_o), .pend_o(pend_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [AB-1:0] act, input logic [AB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic breq(input logic [CRW-1:0] c, input logic s, input logic p,
                      input logic [AB-1:0] t, input logic [AB-1:0] f);
    br_req_i = 1; br_cr_i = c; br_sense_i = s; br_pred_i = p;
    br_target_i = t; br_fallthru_i = f;
  endtask

  // Monitor: every accepted result must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (!rst_i && res_valid_o && res_ready_i) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: result pc=0x%0h with nothing expected", res_pc_o);
      end else begin
        logic [AB+1:0] e;
        e = expq.pop_front();
        if ({res_taken_o, res_mispred_o, res_pc_o} !== e) begin
          errors++;
          $display("FAIL sb_result: got taken=%0b mispred=%0b pc=0x%0h expected taken=%0b mispred=%0b pc=0x%0h",
                   res_taken_o, res_mispred_o, res_pc_o, e[AB+1], e[AB], e[AB-1:0]);
        end
      end
    end
  end

  initial begin
    tick(); tick();
    chk("rst_cr", AB'(cr_o), 0);
    chk("rst_pend", AB'(pend_o), 0);
    chk("rst_ready", AB'(br_ready_o), 1);
    chk("rst_valid", AB'(res_valid_o), 0);
    chk("rst_taken", AB'(res_taken_o), 0);
    chk("rst_mispred", AB'(res_mispred_o), 0);
    chk("rst_pc", res_pc_o, 0);
    rst_i = 0;
    tick();

    // Ready CR, held under backpressure
    cmp_wr_i = 1; cmp_wr_cr_i = 3; cmp_res_i = 1;
    tick();
    cmp_wr_i = 0;
    chk("t1_cr", AB'(cr_o), 32'h08);
    breq(3, 1, 0, 32'h1000, 32'h0F04);
    expq.push_back({1'b1, 1'b1, 32'h1000});
    tick();
    br_req_i = 0;
    chk("t1_valid", AB'(res_valid_o), 1);
    chk("t1_ready", AB'(br_ready_o), 0);
    chk("t1_pc", res_pc_o, 32'h1000);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t1_hold_valid", AB'(res_valid_o), 1);
      chk("t1_hold_pc", res_pc_o, 32'h1000);
    end
    res_ready_i = 1;
    tick();
    chk("t1_idle_valid", AB'(res_valid_o), 0);
    chk("t1_idle_ready", AB'(br_ready_o), 1);

    // Stall on pending CR
    cmp_issue_i = 1; cmp_issue_cr_i = 5;
    tick();
    cmp_issue_i = 0;
    chk("t2_pend", AB'(pend_o), 32'h20);
    breq(5, 0, 0, 32'h2000, 32'h1F08);
    expq.push_back({1'b1, 1'b1, 32'h2000});
    tick();
    br_req_i = 0;
    chk("t2_wait_ready", AB'(br_ready_o), 0);
    chk("t2_wait_valid", AB'(res_valid_o), 0);
    tick(); tick(); tick();
    chk("t2_still_wait", AB'(res_valid_o), 0);
    cmp_wr_i = 1; cmp_wr_cr_i = 5; cmp_res_i = 0;
    tick();
    cmp_wr_i = 0;
    chk("t2_valid", AB'(res_valid_o), 1);
    chk("t2_pend0", AB'(pend_o), 0);
    chk("t2_pc", res_pc_o, 32'h2000);
    tick();
    chk("t2_idle", AB'(br_ready_o), 1);

    // Bypass from same-cycle write
    cmp_issue_i = 1; cmp_issue_cr_i = 2;
    tick();
    cmp_issue_i = 0;
    chk("t3_pend", AB'(pend_o), 32'h04);
    breq(2, 1, 0, 32'h3000, 32'h3004);
    cmp_wr_i = 1; cmp_wr_cr_i = 2; cmp_res_i = 0;
    expq.push_back({1'b0, 1'b0, 32'h3004});
    tick();
    br_req_i = 0; cmp_wr_i = 0;
    chk("t3_valid", AB'(res_valid_o), 1);
    chk("t3_pc", res_pc_o, 32'h3004);
    chk("t3_pend0", AB'(pend_o), 0);
    tick();

    // Issue/write collision, then wait through an unrelated write and a re-issue
    cmp_issue_i = 1; cmp_issue_cr_i = 1;
    cmp_wr_i = 1; cmp_wr_cr_i = 1; cmp_res_i = 1;
    tick();
    cmp_issue_i = 0; cmp_wr_i = 0;
    chk("t4_cr1", AB'(cr_o[1]), 1);
    chk("t4_pend1", AB'(pend_o[1]), 1);
    breq(1, 1, 1, 32'h4000, 32'h4004);
    expq.push_back({1'b1, 1'b0, 32'h4000});
    tick();
    br_req_i = 0;
    chk("t4_wait", AB'(res_valid_o), 0);
    cmp_wr_i = 1; cmp_wr_cr_i = 6; cmp_res_i = 1;
    tick();
    cmp_wr_i = 0;
    chk("t4_other_wr", AB'(res_valid_o), 0);
    cmp_issue_i = 1; cmp_issue_cr_i = 1;
    tick();
    cmp_issue_i = 0;
    chk("t4_reissue", AB'(res_valid_o), 0);
    cmp_wr_i = 1; cmp_wr_cr_i = 1; cmp_res_i = 1;
    tick();
    cmp_wr_i = 0;
    chk("t4_valid", AB'(res_valid_o), 1);
    chk("t4_pc", res_pc_o, 32'h4000);
    chk("t4_cr", AB'(cr_o), 32'h4A);
    tick();

    // Flush while waiting; request and issue in the flush cycle are dropped
    cmp_issue_i = 1; cmp_issue_cr_i = 3;
    tick();
    cmp_issue_cr_i = 4;
    tick();
    cmp_issue_i = 0;
    chk("t5_pend", AB'(pend_o), 32'h18);
    breq(4, 1, 0, 32'h5000, 32'h5004);
    tick();
    chk("t5_wait", AB'(br_ready_o), 0);
    flush_i = 1;
    breq(0, 1, 0, 32'h5100, 32'h5104);
    cmp_issue_i = 1; cmp_issue_cr_i = 7;
    tick();
    flush_i = 0; br_req_i = 0; cmp_issue_i = 0;
    chk("t5_ready", AB'(br_ready_o), 1);
    chk("t5_valid", AB'(res_valid_o), 0);
    chk("t5_pend0", AB'(pend_o), 0);
    tick();
    chk("t5_not_accepted", AB'(res_valid_o), 0);
    cmp_wr_i = 1; cmp_wr_cr_i = 4; cmp_res_i = 1;
    tick();
    cmp_wr_i = 0;
    chk("t5_cr_after", AB'(cr_o), 32'h5A);

    // Backpressure, then asynchronous reset in DONE
    res_ready_i = 0;
    breq(4, 1, 1, 32'h6000, 32'h6004);
    tick();
    br_req_i = 0;
    chk("t6_valid", AB'(res_valid_o), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_hold_valid", AB'(res_valid_o), 1);
      chk("t6_hold_taken", AB'(res_taken_o), 1);
      chk("t6_hold_mispred", AB'(res_mispred_o), 0);
      chk("t6_hold_pc", res_pc_o, 32'h6000);
    end
    #2 rst_i = 1;
    #1;
    chk("t6_rst_valid", AB'(res_valid_o), 0);
    chk("t6_rst_cr", AB'(cr_o), 0);
    chk("t6_rst_ready", AB'(br_ready_o), 1);
    tick();
    rst_i = 0;
    tick();
    chk("sb_drained", AB'(expq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rfblackwidow_cond_resolve.md
Name: rfblackwidow_cond_resolve

Overview:
- Consumer end of the compare path: compare results are written into a small condition-register (CR) file with a pending scoreboard.
- Conditional branches request resolution against a CR. They stall until that CR's compare result is written.
- Outputs taken/not-taken, misprediction flag and redirect PC to fetch, over a valid/ready handshake.

Parameters:
- NCR, 8, number of condition registers (power of 2, min 2)
- CRW, $clog2(NCR), CR index width (derived)
- ABITS, 32, PC/address width

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- flush_i  input  1  pipeline flush; squashes in-flight compares and any branch in progress
- cmp_issue_i  input  1  a compare targeting cmp_issue_cr_i was issued; mark CR pending
- cmp_issue_cr_i  input  CRW  CR index of issued compare
- cmp_wr_i  input  1  compare result write strobe
- cmp_wr_cr_i  input  CRW  CR index written
- cmp_res_i  input  1  compare result bit
- br_req_i  input  1  branch resolution request
- br_ready_o  output  1  block can accept a request
- br_cr_i  input  CRW  CR tested by branch
- br_sense_i  input  1  branch taken when CR == br_sense_i
- br_pred_i  input  1  predicted taken
- br_target_i  input  ABITS  taken target
- br_fallthru_i  input  ABITS  not-taken PC
- res_valid_o  output  1  resolution result valid
- res_ready_i  input  1  consumer accepts result
- res_taken_o  output  1  branch taken
- res_mispred_o  output  1  res_taken_o != latched prediction
- res_pc_o  output  ABITS  res_taken_o ? target : fallthru
- cr_o  output  NCR  current CR values
- pend_o  output  NCR  current pending bits

Behaviour:
- Reset: cr_o=0, pend_o=0, state IDLE, br_ready_o=1, res_valid_o=0, res_taken_o=0, res_mispred_o=0, res_pc_o=0. Reset mid-operation drops any latched branch immediately.
- CR file, per clock:
  - cmp_wr_i: cr[cmp_wr_cr_i] <= cmp_res_i; pend[cmp_wr_cr_i] <= 0.
  - cmp_issue_i: pend[cmp_issue_cr_i] <= 1.
  - Same CR issued and written in the same cycle: value updates and pend ends at 1 (younger issue wins).
  - A write to a non-pending CR still updates the value.
- Flush:
  - pend <= all 0 and CR values are retained. A cmp_issue_i in the flush cycle is ignored.
  - Any later cmp_wr_i still updates the value.
  - FSM returns to IDLE and res_valid_o <= 0.
- FSM states IDLE, WAIT, DONE:
  - IDLE: br_ready_o=1. On br_req_i, latch cr index, sense, pred, target and fallthru.
    - Bypass: cmp_wr_i && cmp_wr_cr_i==br_cr_i uses cmp_res_i as the CR value; go to DONE.
    - Else if !pend[br_cr_i], use cr[br_cr_i]; go to DONE.
    - Else go to WAIT.
  - WAIT: br_ready_o=0. When cmp_wr_i && cmp_wr_cr_i==latched cr, evaluate with cmp_res_i and go to DONE. Writes to other CRs are ignored by the FSM.
  - DONE: res_valid_o=1, br_ready_o=0, outputs stable. On res_ready_i go to IDLE; a new request may be accepted the following cycle, not the same cycle.
- Evaluation, registered on entry to DONE:
  - taken = (crval == sense)
  - mispred = taken ^ pred
  - pc = taken ? target : fallthru
- Latency:
  - Accept in cycle N with CR ready (or bypassed) gives res_valid_o in N+1.
  - In WAIT, a matching write in cycle M gives res_valid_o in M+1.
- flush_i has priority over every FSM transition and over a br_req_i in the same cycle, which is not accepted.
- An issue to the latched CR while in WAIT keeps waiting; the first matching write resolves it.

Test Plan:
- Ready CR: reset; write cr3=1; next cycle br_req(cr=3, sense=1, pred=0, target=0x1000, fallthru=0x0F04) -> one cycle later res_valid=1, taken=1, mispred=1, pc=0x1000; held until res_ready.
- Stall: issue cr5 (pend_o=0x20); br_req(cr=5, sense=0, pred=0, target=0x2000, fallthru=0x1F08) -> WAIT, br_ready=0; 4 cycles later write cr5=0 -> next cycle taken=1, mispred=1, pc=0x2000, pend_o=0.
- Bypass: cr2 pending; br_req(cr=2, sense=1, pred=0) in the same cycle as write cr2=0 -> next cycle taken=0, mispred=0, pc=fallthru.
- Issue/write collision: issue and write on cr1 in the same cycle with res=1 -> cr_o[1]=1, pend_o[1]=1; subsequent br on cr1 waits.
- Flush: branch in WAIT on cr4, pend=0x18; assert flush_i -> next cycle IDLE, br_ready=1, pend_o=0, res_valid=0; a br_req in the flush cycle is not accepted.
- Backpressure/reset: DONE with res_ready=0 for 3 cycles -> outputs stable; assert rst_i asynchronously mid-DONE -> res_valid=0 and cr_o=0 immediately.
